// File: rtl/flag_pkg.sv
// Shared definitions for the flag source/checker pair: default widths and the
// checker state encoding.
package flag_pkg;

  localparam int unsigned N_BIT_DEF = 5;
  localparam int unsigned DUMP_DEF  = 10;

  typedef enum logic [1:0] {
    StIdle,
    StSeek,
    StMeasure,
    StLocked
  } fpc_state_e;

  function automatic logic in_tol(input int meas, input int period, input int tol);
    return (meas >= period - tol) && (meas <= period + tol);
  endfunction

endpackage

// File: rtl/flag_period_checker.sv
// Receive-side checker for the periodic flag pulse: measures flag spacing, locks after LOCK_CNT
// good periods, flags bad periods and timeouts. Define FPC_ERR_CNT_EN to add err_count.
module flag_period_checker
  import flag_pkg::*;
#(
  parameter int unsigned N_BIT    = N_BIT_DEF,
  parameter int unsigned DUMP     = DUMP_DEF,
  parameter int unsigned TOL      = 0,
  parameter int unsigned LOCK_CNT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             flag_in,
  output logic [N_BIT-1:0] period_meas,
  output logic             meas_valid,
  output logic             period_err,
  output logic             timeout,
  output logic             locked
`ifdef FPC_ERR_CNT_EN
  ,
  output logic [15:0]      err_count
`endif
);

  localparam int unsigned GR_W = $clog2(LOCK_CNT + 1);

  localparam logic [N_BIT-1:0] IVL_LIM = N_BIT'(DUMP + TOL + 1);
  localparam logic [N_BIT-1:0] IVL_MAX = '1;
  localparam logic [GR_W-1:0]  GR_LOCK = GR_W'(LOCK_CNT);

  fpc_state_e       state;
  logic [N_BIT-1:0] ivl;
  logic [GR_W-1:0]  good_run;
  logic [GR_W-1:0]  good_run_inc;
  logic             ivl_good;

  always_comb begin
    good_run_inc = (good_run == GR_LOCK) ? good_run : good_run + 1'b1;
    ivl_good     = in_tol(int'(ivl), int'(DUMP + 1), int'(TOL));
  end

  // rst_n is active-high: it matches the flag source's reset net.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state       <= StIdle;
      ivl         <= '0;
      good_run    <= '0;
      period_meas <= '0;
      meas_valid  <= 1'b0;
      period_err  <= 1'b0;
      timeout     <= 1'b0;
      locked      <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      period_err <= 1'b0;
      timeout    <= 1'b0;
      if (!enable) begin
        state    <= StIdle;
        ivl      <= '0;
        good_run <= '0;
        locked   <= 1'b0;
      end else begin
        unique case (state)
          StIdle: state <= StSeek;
          StSeek: begin
            if (flag_in) begin
              state <= StMeasure;
              ivl   <= N_BIT'(1);
            end
          end
          StMeasure, StLocked: begin
            // A flag on the timeout cycle is still a valid measurement.
            if (flag_in) begin
              period_meas <= ivl;
              meas_valid  <= 1'b1;
              ivl         <= N_BIT'(1);
              if (ivl_good) begin
                good_run <= good_run_inc;
                if (good_run_inc == GR_LOCK) begin
                  state  <= StLocked;
                  locked <= 1'b1;
                end
              end else begin
                period_err <= 1'b1;
                good_run   <= '0;
                locked     <= 1'b0;
                state      <= StMeasure;
              end
            end else if (ivl == IVL_LIM) begin
              timeout  <= 1'b1;
              locked   <= 1'b0;
              good_run <= '0;
              state    <= StSeek;
              ivl      <= '0;
            end else if (ivl != IVL_MAX) begin
              ivl <= ivl + 1'b1;
            end
          end
        endcase
      end
    end
  end

`ifdef FPC_ERR_CNT_EN
  // Counts the registered error pulses; survives enable=0, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      err_count <= '0;
    end else if ((period_err || timeout) && (err_count != 16'hFFFF)) begin
      err_count <= err_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_flag_period_checker.sv
// Self-checking bench for flag_period_checker (DUMP=10, LOCK_CNT=4; second instance with TOL=1).
// Measurement results are checked through a scoreboard queue; define FPC_ERR_CNT_EN to test err_count.
module tb_flag_period_checker;

  localparam int P = 11;

  typedef struct packed {
    logic [4:0] meas;
    logic       err;
    logic       lock;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n, enable, en_tol, flag_in;
  logic [4:0] period_meas, t_period_meas;
  logic       meas_valid, period_err, timeout, locked;
  logic       t_meas_valid, t_period_err, t_timeout, t_locked;
`ifdef FPC_ERR_CNT_EN
  logic [15:0] err_count, t_err_count;
`endif

  int   checks = 0;
  int   errors = 0;
  int   exp_to = 0;
  int   obs_to = 0;
  int   run    = 0;
  bit   have_ref = 1'b0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  flag_period_checker #(.N_BIT(5), .DUMP(10), .TOL(0), .LOCK_CNT(4)) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .flag_in     (flag_in),
    .period_meas (period_meas),
    .meas_valid  (meas_valid),
    .period_err  (period_err),
    .timeout     (timeout),
    .locked      (locked)
`ifdef FPC_ERR_CNT_EN
    ,
    .err_count   (err_count)
`endif
  );

  flag_period_checker #(.N_BIT(5), .DUMP(10), .TOL(1), .LOCK_CNT(4)) u_tol (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (en_tol),
    .flag_in     (flag_in),
    .period_meas (t_period_meas),
    .meas_valid  (t_meas_valid),
    .period_err  (t_period_err),
    .timeout     (t_timeout),
    .locked      (t_locked)
`ifdef FPC_ERR_CNT_EN
    ,
    .err_count   (t_err_count)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check(tag, 32'({period_meas, meas_valid, period_err, timeout, locked}), 32'd0);
  endtask

  // Flag sampled gap edges after the previous one; expected result queued for the monitor.
  task automatic send_flag(input int gap);
    exp_t e;
    bit   good;
    repeat (gap - 1) begin
      flag_in = 1'b0;
      tick();
    end
    flag_in = 1'b1;
    if (have_ref) begin
      good   = (gap == P);
      run    = good ? ((run < 4) ? run + 1 : 4) : 0;
      e.meas = 5'(gap);
      e.err  = !good;
      e.lock = (run == 4);
      exp_q.push_back(e);
    end
    have_ref = 1'b1;
    tick();
    flag_in = 1'b0;
  endtask

  task automatic tol_flag(input int gap);
    repeat (gap - 1) begin
      flag_in = 1'b0;
      tick();
    end
    flag_in = 1'b1;
    tick();
    flag_in = 1'b0;
  endtask

  task automatic expect_timeout();
    int k;
    bit seen;
    k    = 0;
    seen = 1'b0;
    for (int i = 1; i <= 20 && !seen; i++) begin
      flag_in = 1'b0;
      tick();
      if (timeout) begin
        seen = 1'b1;
        k    = i;
      end
    end
    check("timeout_delay", 32'(k), 32'(P));
    check("timeout_unlock", 32'(locked), 32'd0);
    exp_to++;
    have_ref = 1'b0;
    run      = 0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (timeout) obs_to++;
    if (meas_valid) begin
      check("meas_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("period_meas", 32'(period_meas), 32'(e.meas));
        check("period_err", 32'(period_err), 32'(e.err));
        check("locked_at_meas", 32'(locked), 32'(e.lock));
      end
    end else begin
      check("stray_period_err", 32'(period_err), 32'd0);
    end
  end

  initial begin
    rst_n   = 1'b1;
    enable  = 1'b1;
    en_tol  = 1'b0;
    flag_in = 1'b0;

    // Outputs stay zero under reset even with flags arriving.
    for (int i = 0; i < 22; i++) begin
      flag_in = (i % 11 == 10);
      tick();
      check_zero("reset_outputs");
    end
    flag_in = 1'b0;
    rst_n   = 1'b0;

    send_flag(3);
    check("first_flag_no_meas", 32'(meas_valid), 32'd0);
    repeat (4) send_flag(P);
    check("lock_after_4", 32'(locked), 32'd1);
    check("meas_11", 32'(period_meas), 32'd11);

    // Short period while locked.
    send_flag(9);
    check("bad_unlocks", 32'(locked), 32'd0);
    check("bad_meas_9", 32'(period_meas), 32'd9);
    repeat (3) send_flag(P);
    check("not_yet_relocked", 32'(locked), 32'd0);
    send_flag(P);
    check("relock_after_bad", 32'(locked), 32'd1);

    // Flags stop, then resume.
    expect_timeout();
    send_flag(3);
    repeat (3) send_flag(P);
    check("no_lock_before_5th", 32'(locked), 32'd0);
    send_flag(P);
    check("relock_after_timeout", 32'(locked), 32'd1);

    // Enable dropped for 3 clocks while locked; flags meanwhile ignored.
    enable = 1'b0;
    tick();
    check("disable_unlocks", 32'(locked), 32'd0);
    flag_in = 1'b1;
    tick();
    flag_in = 1'b0;
    tick();
    check("disable_no_meas", 32'(meas_valid), 32'd0);
    check("meas_hold", 32'(period_meas), 32'd11);
    enable   = 1'b1;
    have_ref = 1'b0;
    run      = 0;
    send_flag(4);
    check("restart_no_meas", 32'(meas_valid), 32'd0);
    repeat (4) send_flag(P);
    check("relock_after_enable", 32'(locked), 32'd1);

    // Reset pulse mid-period.
    repeat (5) begin
      flag_in = 1'b0;
      tick();
    end
    rst_n = 1'b1;
    tick();
    check_zero("mid_reset");
    rst_n    = 1'b0;
    have_ref = 1'b0;
    run      = 0;

    // TOL=1 instance, periods 10, 12, 11, 10.
    enable = 1'b0;
    tick();
    en_tol = 1'b1;
    tick();
    tol_flag(3);
    check("tol_ref_no_meas", 32'(t_meas_valid), 32'd0);
    tol_flag(10);
    check("tol_meas_10", 32'({t_meas_valid, t_period_meas}), 32'({1'b1, 5'd10}));
    check("tol_err_10", 32'(t_period_err), 32'd0);
    tol_flag(12);
    check("tol_meas_12", 32'({t_meas_valid, t_period_meas}), 32'({1'b1, 5'd12}));
    check("tol_err_12", 32'(t_period_err), 32'd0);
    check("tol_no_timeout", 32'(t_timeout), 32'd0);
    tol_flag(11);
    check("tol_not_locked_3", 32'(t_locked), 32'd0);
    tol_flag(10);
    check("tol_err_last", 32'(t_period_err), 32'd0);
    check("tol_locked_4", 32'(t_locked), 32'd1);
    en_tol = 1'b0;
    tick();

`ifdef FPC_ERR_CNT_EN
    rst_n = 1'b1;
    tick();
    rst_n  = 1'b0;
    enable = 1'b1;
    send_flag(3);
    repeat (3) send_flag(9);
    expect_timeout();
    tick();
    check("err_count_4", 32'(err_count), 32'd4);
    enable = 1'b0;
    tick();
    tick();
    enable = 1'b1;
    tick();
    check("err_count_keep", 32'(err_count), 32'd4);
    rst_n = 1'b1;
    tick();
    check("err_count_reset", 32'(err_count), 32'd0);
    rst_n    = 1'b0;
    have_ref = 1'b0;
    run      = 0;
`endif

    repeat (3) tick();
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("timeout_count", 32'(obs_to), 32'(exp_to));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
